// File: rtl/vga_dither_out.sv
// -----------------------------------------------------------------------------
// vga_dither_out
//
// VGA output stage for Next186lite boards. Each IN_W-bit colour channel is
// reduced to the OUT_W-bit board DAC width with 4x4 ordered (Bayer)
// dithering. Plain MSB truncation is not used. Syncs and DE are carried
// through the same two-stage pipeline as the colour, so the sync/colour
// relationship at the pins matches the one at the inputs.
//
// Parameters:
//   IN_W      input bits per colour channel
//   OUT_W     output bits per channel (1 <= IN_W-OUT_W <= 4)
//   SYNC_POL  active level of HSYNC/VSYNC (0 = active-low)
//
// Ports:
//   CLK                    pixel-domain clock; all logic uses the rising edge
//   RST                    asynchronous, active-high reset
//   CE                     pixel enable; all state holds while CE=0
//   R_IN, G_IN, B_IN       colour inputs, IN_W bits
//   DE_IN                  active video (1 = visible pixel)
//   HSYNC_IN, VSYNC_IN     syncs, active level set by SYNC_POL
//   R_OUT, G_OUT, B_OUT    dithered colour to the DAC, OUT_W bits
//   HSYNC_OUT, VSYNC_OUT   syncs delayed by the pipeline latency
//
// Configuration macro:
//   VGA_DITHER_TEMPORAL_EN  When this macro is defined, a 2-bit frame counter
//                           offsets the Bayer index every frame. The residual
//                           error is then spread over 4 frames. When it is
//                           undefined, the pattern is static.
//
// Latency is two CE-qualified edges for colour, DE and syncs in both builds.
// -----------------------------------------------------------------------------
module vga_dither_out #(
  parameter int IN_W     = 6,
  parameter int OUT_W    = 3,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic [IN_W-1:0]  R_IN,
  input  logic [IN_W-1:0]  G_IN,
  input  logic [IN_W-1:0]  B_IN,
  input  logic             DE_IN,
  input  logic             HSYNC_IN,
  input  logic             VSYNC_IN,
  output logic [OUT_W-1:0] R_OUT,
  output logic [OUT_W-1:0] G_OUT,
  output logic [OUT_W-1:0] B_OUT,
  output logic             HSYNC_OUT,
  output logic             VSYNC_OUT
);

  localparam int   D         = IN_W - OUT_W;
  localparam logic SYNC_IDLE = ~SYNC_POL;

  if (D < 1 || D > 4) begin : g_bad_width
    $error("vga_dither_out: IN_W-OUT_W must be in 1..4");
  end

  // 4x4 Bayer matrix. The entries are stored row-major, so the index is {y, x}.
  localparam logic [3:0] BAYER [16] = '{
    4'd0,  4'd8,  4'd2,  4'd10,
    4'd12, 4'd4,  4'd14, 4'd6,
    4'd3,  4'd11, 4'd1,  4'd9,
    4'd15, 4'd7,  4'd13, 4'd5
  };

  // ---------------------------------------------------------------------------
  // Screen position tracking
  // ---------------------------------------------------------------------------
  logic [1:0] x, y;
  logic       hs_q, vs_q;
  logic       hs_edge, vs_edge;

  // Assertion edges are detected against the copies registered on the previous CE.
  assign hs_edge = (HSYNC_IN == SYNC_POL) && (hs_q != SYNC_POL);
  assign vs_edge = (VSYNC_IN == SYNC_POL) && (vs_q != SYNC_POL);

  // NOTE: every clocked block uses non-blocking assignments only. Each register
  // then samples the pre-edge values of the other registers, whatever order
  // the blocks are written in.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      x    <= '0;
      y    <= '0;
      hs_q <= SYNC_IDLE;
      vs_q <= SYNC_IDLE;
    end else if (CE) begin
      hs_q <= HSYNC_IN;
      vs_q <= VSYNC_IN;
      // When both syncs assert on the same CE, VSYNC has priority and the
      // pattern restarts at the top-left corner.
      if (vs_edge) begin
        x <= '0;
        y <= '0;
      end else if (hs_edge) begin
        x <= '0;
        y <= y + 2'd1;
      end else if (DE_IN) begin
        x <= x + 2'd1;
      end
    end
  end

  logic [1:0] xi, yi;

`ifdef VGA_DITHER_TEMPORAL_EN
  logic [1:0] f;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      f <= '0;
    end else if (CE && vs_edge) begin
      f <= f + 2'd1;
    end
  end

  // Every frame the matrix shifts by f columns and by f[1] rows.
  assign xi = x + f;
  assign yi = y + {1'b0, f[1]};
`else
  assign xi = x;
  assign yi = y;
`endif

  // Only the top D bits of the 4-bit matrix entry are used, so the
  // threshold spans 0..2^D-1.
  logic [D-1:0] t_c;
  assign t_c = D'(BAYER[{yi, xi}] >> (4 - D));

  // ---------------------------------------------------------------------------
  // Stage 1: register colour, DE, syncs and the threshold
  // ---------------------------------------------------------------------------
  logic [IN_W-1:0] r1, g1, b1;
  logic [D-1:0]    t1;
  logic            de1, hs1, vs1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r1  <= '0;
      g1  <= '0;
      b1  <= '0;
      t1  <= '0;
      de1 <= 1'b0;
      hs1 <= SYNC_IDLE;
      vs1 <= SYNC_IDLE;
    end else if (CE) begin
      r1  <= R_IN;
      g1  <= G_IN;
      b1  <= B_IN;
      t1  <= t_c;
      de1 <= DE_IN;
      hs1 <= HSYNC_IN;
      vs1 <= VSYNC_IN;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: add the threshold, drop D bits, saturate, blank
  // ---------------------------------------------------------------------------
  // The sum is computed at IN_W+1 bits, so the shifted result is OUT_W+1 bits
  // wide. Its top bit is set only when the dithered value overflows the DAC
  // range.
  function automatic logic [OUT_W-1:0] dither_sat(input logic [IN_W-1:0] c,
                                                  input logic [D-1:0]    t);
    logic [OUT_W:0] q;
    q = (OUT_W+1)'(({1'b0, c} + (IN_W+1)'(t)) >> D);
    return q[OUT_W] ? '1 : q[OUT_W-1:0];
  endfunction

  // Blanking is applied while stage 2 is loaded. The pins therefore come
  // straight from flops, and colour is zero whenever the delayed DE is low.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      R_OUT     <= '0;
      G_OUT     <= '0;
      B_OUT     <= '0;
      HSYNC_OUT <= SYNC_IDLE;
      VSYNC_OUT <= SYNC_IDLE;
    end else if (CE) begin
      R_OUT     <= de1 ? dither_sat(r1, t1) : '0;
      G_OUT     <= de1 ? dither_sat(g1, t1) : '0;
      B_OUT     <= de1 ? dither_sat(b1, t1) : '0;
      HSYNC_OUT <= hs1;
      VSYNC_OUT <= vs1;
    end
  end

endmodule

// File: doc/vga_dither_out.md
# vga_dither_out

Parametrised VGA output stage for Next186lite boards. Reduces IN_W-bit colour channels to the OUT_W-bit board DAC width with 4x4 ordered (Bayer) dithering instead of plain MSB truncation. Delays syncs and blanking to stay aligned with the colour pipeline. Sits between the system's VGA outputs and the board VGA pins in each board top level.

## Interface
Parameters:
- IN_W, 6, input bits per colour channel
- OUT_W, 3, output bits per channel; D = IN_W-OUT_W must satisfy 1 <= D <= 4, else elaboration error
- SYNC_POL, 0, sync active level (0 = active-low)

Ports:
- CLK  in  1  pixel-domain clock; one clock, all logic on rising edge
- RST  in  1  reset, asynchronous, active-high
- CE  in  1  pixel enable; state advances only when CE=1
- R_IN, G_IN, B_IN  in  IN_W  colour inputs
- DE_IN  in  1  active video (1 = visible pixel)
- HSYNC_IN, VSYNC_IN  in  1  syncs, polarity per SYNC_POL
- R_OUT, G_OUT, B_OUT  out  OUT_W  dithered colour to DAC
- HSYNC_OUT, VSYNC_OUT  out  1  delayed syncs

## Operation
- Position tracking: 2-bit x, 2-bit y and 2-bit frame counter f.
  - x increments (mod 4) on each CE with DE_IN=1.
  - x clears on a HSYNC_IN assertion edge.
  - y increments (mod 4) on each HSYNC_IN assertion edge.
  - y and x clear on a VSYNC_IN assertion edge, and f increments there.
  - Edge detect uses a CE-qualified registered copy of each sync.
- Simultaneous HSYNC and VSYNC assertion in the same CE: VSYNC wins, so x=0, y=0, f+1.
- Bayer matrix B[y][x], rows y=0..3: 0 8 2 10 / 12 4 14 6 / 3 11 1 9 / 15 7 13 5.
- Threshold t = B[yi][xi] >> (4-D), giving range 0..2^D-1.
- Index: xi = x, yi = y (temporal disabled, see Configuration).
- Per channel: s = c + t, computed at IN_W+1 bits. Output is s >> D, saturated to 2^OUT_W-1 if it overflows OUT_W.
- Blanking: when the delayed DE is 0, the colour outputs are forced to 0.
- Pipeline stage 1 registers colour, DE, syncs and t. Stage 2 registers the sum/saturate result, delayed DE and syncs. Both stages load only on CE=1.

## Timing
- Latency: exactly 2 CE-qualified clock edges from inputs to outputs, identical for colour, DE and syncs. Sync/colour relationship is preserved exactly.
- CE=0: all registers and counters hold.
- Reset values:
  - R/G/B_OUT = 0.
  - HSYNC_OUT and VSYNC_OUT = inactive level (1 when SYNC_POL=0).
  - x, y, f = 0; pipeline DE = 0; registered sync copies = inactive.
- Reset mid-line: outputs go to reset values immediately (asynchronous). The first pixel after release uses t = B[0][0].
- No handshake; the block is free-running with the video timing.

## Configuration
- VGA_DITHER_TEMPORAL_EN defined:
  - xi = x + f (mod 4) and yi = y + f[1] (mod 4).
  - The pattern shifts every frame, averaging the residual error over 4 frames.
- Undefined: f is not implemented, xi = x, yi = y, and the pattern is static.
- Latency is identical in both builds.

## Test plan
All cases use IN_W=6, OUT_W=3, so t per row is 0 4 1 5 / 6 2 7 3 / 1 5 0 4 / 7 3 6 2.
- Static dither: macro off, CE=1, constant R_IN=20, DE_IN=1 after a VSYNC. Row 0 R_OUT = 2,3,2,3; row 1 R_OUT = 3,2,3,2; the pattern repeats every 4 pixels and lines.
- Saturation/floor: input 63 -> output 7 at all 16 positions; input 0 -> output 0 at all positions; input 56 -> output 7 everywhere with no wrap to 0.
- Blanking and latency: CE toggling 1-of-2 clocks, DE_IN low with colour 63. Outputs stay 0. A HSYNC_IN falling edge appears on HSYNC_OUT exactly 2 CE pulses (4 clocks) later.
- Sync collision: HSYNC and VSYNC asserted on the same CE mid-frame (x=2, y=3). The next visible pixel uses t = B[0][0] = 0, so input 20 -> output 2.
- Temporal (macro on): frame f=1, constant input 20. Row 0 output = 3,2,3,2. Frame f=0 output = 2,3,2,3.
- Async reset: assert RST mid-line for a fraction of a clock. Outputs go to 0 and inactive syncs without a clock edge. After release the first visible pixel at input 20 -> output 2.
